// File: rtl/ln_arb_pkg.sv
// Shared types for the layer-norm row arbiter: FSM state encoding and stats width.
package ln_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int unsigned STATS_W = 32;

endpackage

// File: rtl/ln_row_counter.sv
// Beat counter for one row: tracks the column index, flags the last beat and wraps on it.
module ln_row_counter #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] len,
  input  logic         advance,
  output logic         last,
  output logic         wrap
);

  logic [W-1:0] col_cntr;

  assign last = (col_cntr == len - W'(1));
  assign wrap = advance & last;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cntr <= '0;
    end else if (wrap) begin
      col_cntr <= '0;
    end else if (advance) begin
      col_cntr <= col_cntr + W'(1);
    end
  end

endmodule

// File: rtl/ln_row_arbiter.sv
// Round-robin row arbiter feeding two requester streams into one layer-norm unit.
// Define LN_ROW_ARB_STATS_EN to add per-requester completed-row counters rows0/rows1.
module ln_row_arbiter
  import ln_arb_pkg::*;
#(
  parameter int unsigned D_W_ACC      = 32,
  parameter int unsigned MATRIXSIZE_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [D_W_ACC-1:0]      s0_tdata,
  input  logic                    s0_tvalid,
  output logic                    s0_tready,
  input  logic [D_W_ACC-1:0]      s1_tdata,
  input  logic                    s1_tvalid,
  output logic                    s1_tready,
  output logic [D_W_ACC-1:0]      m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tid,
  output logic                    m_tlast,
  input  logic [MATRIXSIZE_W-1:0] DIM2,
`ifdef LN_ROW_ARB_STATS_EN
  output logic [STATS_W-1:0]      rows0,
  output logic [STATS_W-1:0]      rows1,
`endif
  output logic                    busy
);

  arb_state_t              state;
  logic [MATRIXSIZE_W-1:0] len;
  logic                    last_served;
  logic                    grant_pick;
  logic                    beat;
  logic                    row_last;
  logic                    row_wrap;

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    if (s0_tvalid && s1_tvalid) begin
      grant_pick = ~last_served;
    end else begin
      grant_pick = s1_tvalid;
    end
  end

  assign busy = (state == XFER);

  always_comb begin
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    if (busy) begin
      if (m_tid) begin
        m_tvalid  = s1_tvalid;
        m_tdata   = s1_tdata;
        s1_tready = m_tready;
      end else begin
        m_tvalid  = s0_tvalid;
        m_tdata   = s0_tdata;
        s0_tready = m_tready;
      end
    end
  end

  assign beat    = m_tvalid & m_tready;
  assign m_tlast = busy & row_last;

  ln_row_counter #(
    .W (MATRIXSIZE_W)
  ) u_row_counter (
    .clk     (clk),
    .rst     (rst),
    .len     (len),
    .advance (beat),
    .last    (row_last),
    .wrap    (row_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len         <= MATRIXSIZE_W'(1);
      m_tid       <= 1'b0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (s0_tvalid || s1_tvalid) begin
            state       <= XFER;
            m_tid       <= grant_pick;
            last_served <= grant_pick;
            len         <= (DIM2 == '0) ? MATRIXSIZE_W'(1) : DIM2;
          end
        end
        XFER: begin
          if (row_wrap) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LN_ROW_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rows0 <= '0;
      rows1 <= '0;
    end else if (row_wrap) begin
      if (!m_tid && rows0 != '1) begin
        rows0 <= rows0 + STATS_W'(1);
      end
      if (m_tid && rows1 != '1) begin
        rows1 <= rows1 + STATS_W'(1);
      end
    end
  end
`else
  // Default build carries no row statistics.
`endif

endmodule

// File: tb/tb_ln_row_arbiter.sv
// Self-checking bench for ln_row_arbiter: vector table, scenario sequences, randomized run vs. a row-level model.
module tb_ln_row_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] s0_tdata;
  logic        s0_tvalid;
  logic        s0_tready;
  logic [31:0] s1_tdata;
  logic        s1_tvalid;
  logic        s1_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tid;
  logic        m_tlast;
  logic [23:0] DIM2;
  logic        busy;
`ifdef LN_ROW_ARB_STATS_EN
  logic [31:0] rows0;
  logic [31:0] rows1;
`endif

  ln_row_arbiter #(
    .D_W_ACC      (32),
    .MATRIXSIZE_W (24)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s0_tdata  (s0_tdata),
    .s0_tvalid (s0_tvalid),
    .s0_tready (s0_tready),
    .s1_tdata  (s1_tdata),
    .s1_tvalid (s1_tvalid),
    .s1_tready (s1_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tid     (m_tid),
    .m_tlast   (m_tlast),
    .DIM2      (DIM2),
`ifdef LN_ROW_ARB_STATS_EN
    .rows0     (rows0),
    .rows1     (rows1),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Row-level reference: whether a row is open, who owns it, its length and beats delivered so far.
  bit m_busy;
  int m_gid;
  int m_len;
  int m_cnt;
  int m_ls;
`ifdef LN_ROW_ARB_STATS_EN
  longint unsigned m_rows[2];
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle_check();
    logic        gv;
    logic [31:0] gd;
    #1;
    gv = (m_gid == 1) ? s1_tvalid : s0_tvalid;
    gd = (m_gid == 1) ? s1_tdata : s0_tdata;
    chk("busy", busy, m_busy);
    chk("m_tvalid", m_tvalid, m_busy && gv);
    chk("m_tlast", m_tlast, m_busy && (m_cnt == m_len - 1));
    chk("s0_tready", s0_tready, m_busy && m_gid == 0 && m_tready);
    chk("s1_tready", s1_tready, m_busy && m_gid == 1 && m_tready);
    if (m_busy) chk("m_tid", m_tid, m_gid);
    if (m_busy && gv) chk("m_tdata", m_tdata, gd);
`ifdef LN_ROW_ARB_STATS_EN
    chk("rows0", rows0, m_rows[0]);
    chk("rows1", rows1, m_rows[1]);
`endif
  endtask

  task automatic model_tick();
    bit gv;
    if (rst) begin
      m_busy = 0; m_gid = 0; m_len = 1; m_cnt = 0; m_ls = 1;
`ifdef LN_ROW_ARB_STATS_EN
      m_rows[0] = 0; m_rows[1] = 0;
`endif
    end else if (!m_busy) begin
      if (s0_tvalid || s1_tvalid) begin
        if (s0_tvalid && s1_tvalid) m_gid = 1 - m_ls;
        else m_gid = s1_tvalid ? 1 : 0;
        m_ls   = m_gid;
        m_busy = 1;
        m_cnt  = 0;
        m_len  = (DIM2 == 0) ? 1 : int'(DIM2);
      end
    end else begin
      gv = (m_gid == 1) ? s1_tvalid : s0_tvalid;
      if (gv && m_tready) begin
        m_cnt++;
        if (m_cnt == m_len) begin
`ifdef LN_ROW_ARB_STATS_EN
          if (m_rows[m_gid] < 64'hFFFF_FFFF) m_rows[m_gid]++;
`endif
          m_busy = 0;
          m_cnt  = 0;
        end
      end
    end
  endtask

  task automatic advance();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b1;
    settle_check();
    advance();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst, s0v, s1v;
    logic [31:0] s0d, s1d;
    logic        rdy;
    logic [23:0] dim2;
    logic        ev, el, eb, es0, es1, etid;
    logic [31:0] ed;
  } vec_t;

  function automatic vec_t mk(logic r, logic a, logic b, logic [31:0] ad, logic [31:0] bd, logic rd,
                              logic [23:0] d, logic ev, logic el, logic eb, logic e0, logic e1,
                              logic et, logic [31:0] ed);
    vec_t v;
    v.rst = r; v.s0v = a; v.s1v = b; v.s0d = ad; v.s1d = bd; v.rdy = rd; v.dim2 = d;
    v.ev = ev; v.el = el; v.eb = eb; v.es0 = e0; v.es1 = e1; v.etid = et; v.ed = ed;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[18];
    int   nxt, beats, c4, rows_done, bir, viol, got, lasts;

    tbl[0]  = mk(0,0,0,32'h0, 32'h0, 1,2,  0,0,0,0,0,0,32'h0);
    tbl[1]  = mk(0,1,1,32'hA1,32'hB1,1,2,  0,0,0,0,0,0,32'h0);
    tbl[2]  = mk(0,1,1,32'hA1,32'hB1,1,2,  1,0,1,1,0,0,32'hA1);
    tbl[3]  = mk(0,1,1,32'hA2,32'hB1,1,5,  1,1,1,1,0,0,32'hA2);
    tbl[4]  = mk(0,1,1,32'hA2,32'hB1,1,2,  0,0,0,0,0,0,32'h0);
    tbl[5]  = mk(0,1,1,32'hA2,32'hB1,0,2,  1,0,1,0,0,1,32'hB1);
    tbl[6]  = mk(0,1,1,32'hA2,32'hB1,1,2,  1,0,1,0,1,1,32'hB1);
    tbl[7]  = mk(0,1,0,32'hA2,32'hB1,1,2,  0,1,1,0,1,1,32'h0);
    tbl[8]  = mk(0,0,1,32'hA2,32'hB2,1,2,  1,1,1,0,1,1,32'hB2);
    tbl[9]  = mk(0,0,0,32'h0, 32'h0, 1,0,  0,0,0,0,0,0,32'h0);
    tbl[10] = mk(0,0,1,32'h0, 32'hB3,1,0,  0,0,0,0,0,0,32'h0);
    tbl[11] = mk(0,0,1,32'h0, 32'hB3,1,0,  1,1,1,0,1,1,32'hB3);
    tbl[12] = mk(0,1,1,32'hA3,32'hB4,1,5,  0,0,0,0,0,0,32'h0);
    tbl[13] = mk(0,1,1,32'hA3,32'hB4,1,5,  1,0,1,1,0,0,32'hA3);
    tbl[14] = mk(0,1,1,32'hA4,32'hB4,1,5,  1,0,1,1,0,0,32'hA4);
    tbl[15] = mk(1,1,1,32'hA5,32'hB4,1,5,  1,0,1,1,0,0,32'hA5);
    tbl[16] = mk(0,1,1,32'hA5,32'hB4,1,5,  0,0,0,0,0,0,32'h0);
    tbl[17] = mk(0,1,1,32'hA5,32'hB4,1,5,  1,0,1,1,0,0,32'hA5);

    rst = 1'b1; s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tdata = '0; s1_tdata = '0;
    m_tready = 1'b1; DIM2 = 24'd2;
    #1;
    model_tick();
    @(posedge clk);
    #1;
    do_reset();

    // Vector table: arbitration, stall, valid gap, DIM2 edge cases, mid-row reset.
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; s0_tvalid = tbl[i].s0v; s1_tvalid = tbl[i].s1v;
      s0_tdata = tbl[i].s0d; s1_tdata = tbl[i].s1d; m_tready = tbl[i].rdy; DIM2 = tbl[i].dim2;
      settle_check();
      chk($sformatf("tbl%0d_valid", i), m_tvalid, tbl[i].ev);
      chk($sformatf("tbl%0d_last", i), m_tlast, tbl[i].el);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("tbl%0d_s0r", i), s0_tready, tbl[i].es0);
      chk($sformatf("tbl%0d_s1r", i), s1_tready, tbl[i].es1);
      if (tbl[i].eb) chk($sformatf("tbl%0d_tid", i), m_tid, tbl[i].etid);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), m_tdata, tbl[i].ed);
      advance();
    end

    // Two 4-beat rows from s0 with one bubble in between.
    do_reset();
    DIM2 = 24'd4; s0_tvalid = 1'b1; s1_tvalid = 1'b0; m_tready = 1'b1;
    nxt = 1; beats = 0; c4 = 0;
    for (int c = 0; c < 60 && beats < 8; c++) begin
      s0_tdata = nxt;
      settle_check();
      if (m_tvalid && m_tready) begin
        beats++;
        chk("s27_data", m_tdata, nxt);
        chk("s27_last", m_tlast, (nxt % 4) == 0);
        chk("s27_tid", m_tid, 0);
        if (nxt == 4) c4 = c;
        if (nxt == 5) chk("s27_gap", c - c4, 2);
        nxt++;
      end
      advance();
    end
    chk("s27_beats", beats, 8);

    // Both requesters saturated: rows alternate s0,s1,s0,s1.
    do_reset();
    DIM2 = 24'd3; s0_tvalid = 1'b1; s1_tvalid = 1'b1;
    rows_done = 0; bir = 0; viol = 0;
    for (int c = 0; c < 60 && rows_done < 4; c++) begin
      s0_tdata = $urandom; s1_tdata = $urandom;
      settle_check();
      if (busy && m_tid == 1'b0 && s1_tready) viol++;
      if (m_tvalid && m_tready) begin
        bir++;
        if (m_tlast) begin
          chk("s28_order", m_tid, rows_done % 2);
          chk("s28_row_len", bir, 3);
          rows_done++;
          bir = 0;
        end
      end
      advance();
    end
    chk("s28_rows", rows_done, 4);
    chk("s28_s1_ready_leak", viol, 0);

    // Toggling m_tready: no drop, no duplicate, one tlast.
    do_reset();
    DIM2 = 24'd4; s0_tvalid = 1'b1; s1_tvalid = 1'b0;
    nxt = 100; got = 0; lasts = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      m_tready = (c % 2) == 0;
      s0_tdata = nxt;
      settle_check();
      if (m_tvalid && m_tready) begin
        chk("s29_data", m_tdata, nxt);
        if (m_tlast) lasts++;
        got++;
        nxt++;
      end
      advance();
    end
    chk("s29_beats", got, 4);
    chk("s29_tlast_count", lasts, 1);

    // DIM2 = 1: every beat is last, grants alternate per beat.
    do_reset();
    DIM2 = 24'd1; s0_tvalid = 1'b1; s1_tvalid = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      s0_tdata = $urandom; s1_tdata = $urandom;
      settle_check();
      if (m_tvalid && m_tready) begin
        chk("s30_last", m_tlast, 1);
        chk("s30_tid", m_tid, got % 2);
        got++;
      end
      advance();
    end
    chk("s30_beats", got, 6);

`ifdef LN_ROW_ARB_STATS_EN
    // Stats: three rows on s0 then two on s1.
    do_reset();
    DIM2 = 24'd2; rows_done = 0;
    for (int c = 0; c < 60 && rows_done < 5; c++) begin
      s0_tvalid = rows_done < 3; s1_tvalid = rows_done >= 3;
      s0_tdata = $urandom; s1_tdata = $urandom;
      settle_check();
      if (m_tvalid && m_tready && m_tlast) rows_done++;
      advance();
    end
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    settle_check();
    chk("s32_rows0", rows0, 3);
    chk("s32_rows1", rows1, 2);
    advance();
`endif

    // Randomized traffic against the row-level model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst       = $urandom_range(0, 99) == 0;
      s0_tvalid = $urandom_range(0, 3) != 0;
      s1_tvalid = $urandom_range(0, 3) != 0;
      s0_tdata  = $urandom;
      s1_tdata  = $urandom;
      m_tready  = $urandom_range(0, 3) != 0;
      DIM2      = 24'($urandom_range(0, 4));
      settle_check();
      advance();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ln_row_arbiter.md
LN_ROW_ARBITER -- requirements
Module: ln_row_arbiter

Interface
REQ-001 The block SHALL have parameter D_W_ACC, default 32, meaning stream data width.
REQ-002 The block SHALL have parameter MATRIXSIZE_W, default 24, meaning dimension/counter width.
REQ-003 The block SHALL have port clk, input, 1, clock.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports s0_tdata/s0_tvalid/s0_tready, input/input/output, D_W_ACC/1/1, requester 0 stream.
REQ-006 The block SHALL have ports s1_tdata/s1_tvalid/s1_tready, input/input/output, D_W_ACC/1/1, requester 1 stream.
REQ-007 The block SHALL have ports m_tdata/m_tvalid/m_tready, output/output/input, D_W_ACC/1/1, stream to the shared layer-norm unit.
REQ-008 The block SHALL have port m_tid, output, 1, index of the granted requester.
REQ-009 The block SHALL have port m_tlast, output, 1, marks the last beat of a row.
REQ-010 The block SHALL have port DIM2, input, MATRIXSIZE_W, row length in beats.
REQ-011 The block SHALL have port busy, output, 1, high while a row is granted.

Function
REQ-012 The FSM SHALL have two states: IDLE and XFER.
- IDLE -> XFER: at least one sX_tvalid is high.
- XFER -> IDLE: accepted beat with col_cntr == len-1.
REQ-013 In IDLE, arbitration SHALL be round-robin.
- Both valid: grant the requester not served last.
- One valid: grant that one.
REQ-014 On entry to XFER, the block SHALL latch the granted index into m_tid and latch DIM2 into len; DIM2 == 0 SHALL be latched as 1.
REQ-015 In XFER, m_tdata/m_tvalid SHALL combinationally mirror the granted sX_tdata/sX_tvalid, and granted sX_tready SHALL equal m_tready; the other sX_tready SHALL be 0.
REQ-016 In IDLE, all sX_tready and m_tvalid SHALL be 0.
- Every row costs one bubble cycle; rows are never back-to-back.
REQ-017 col_cntr SHALL increment on m_tvalid & m_tready, and wrap to 0 on the beat where col_cntr == len-1.
REQ-018 m_tlast SHALL be high when busy and col_cntr == len-1.
REQ-019 The grant SHALL stay locked for the full row regardless of the other requester's tvalid or the granted requester's valid gaps.
REQ-020 A DIM2 change during XFER SHALL have no effect until the next grant.
REQ-021 A beat SHALL never be dropped or duplicated; a stalled m_tready SHALL hold all state.

Reset
REQ-022 Under rst, the block SHALL go to IDLE with col_cntr=0, len=1, m_tid=0, busy=0, m_tvalid=0, s0_tready=0, s1_tready=0, and last-served=1 (s0 wins the first tie).
REQ-023 rst mid-row SHALL abort the row; rst takes priority over any handshake in the same cycle.

Configuration
REQ-024 With `LN_ROW_ARB_STATS_EN` defined, the block SHALL add outputs rows0 and rows1 (32 bits each).
- Each counts completed rows per requester, incremented on the m_tlast beat.
- Each saturates at all-ones and clears on rst.
- Without the macro, these ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-025 Shared package ln_arb_pkg SHALL hold the state enum (IDLE, XFER) and the stats counter width constant.
REQ-026 The row beat counter (col_cntr, wrap, last flag) SHALL be a sub-module named ln_row_counter.

Verification
REQ-027 Scenario: DIM2=4, only s0 valid with data 1..8, m_tready=1 -> two rows with m_tid=0, m_tlast on data 4 and 8, one idle cycle between rows.
REQ-028 Scenario: DIM2=3, both requesters continuously valid -> grant order s0,s1,s0,s1; each row is 3 beats; s1_tready=0 throughout s0 rows.
REQ-029 Scenario: DIM2=4, m_tready toggling 1,0,1,0 -> all 4 beats are delivered in order with no duplicates, and m_tlast is asserted exactly once.
REQ-030 Scenario: DIM2=1 -> every beat carries m_tlast=1, and grants alternate per beat when both requesters are valid.
REQ-031 Scenario: rst asserted after beat 2 of a 5-beat row -> next cycle IDLE, outputs at reset values; the next tie is granted to s0.
REQ-032 Scenario: with `LN_ROW_ARB_STATS_EN`, run 3 rows on s0 and 2 rows on s1 -> rows0=3, rows1=2.
